wash_phase_timer: RTL

- Phase-duration controller for the washing-machine datapath.
- On a start request from the wash FSM, it loads the duration for the FSM's current phase (fill/wash/rinse/spin) and counts it down in seconds, using a clock-cycle prescaler.
- Freezes while pause is held; returns a one-cycle finished pulse to the FSM when the phase expires.
- Sits between the wash FSM (start/state/finished) and the user timer-pause input.

---
 rtl/wash_phase_timer.sv | 109 ++++++++++
 1 files changed

// File: rtl/wash_phase_timer.sv
// Phase-duration countdown for the wash FSM with pause hold and finish pulse.
// Define WASH_TIMER_FAST_SIM_EN to drop the prescaler (one tick per clock).
module wash_phase_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int CNT_W     = 10,
  parameter int FILL_SEC  = 120,
  parameter int WASH_SEC  = 300,
  parameter int RINSE_SEC = 120,
  parameter int SPIN_SEC  = 60
) (
  input  logic             clk_timer,
  input  logic             rst_timer,
  input  logic             start_timer,
  input  logic [2:0]       state_timer,
  input  logic             pause_timer,
  output logic             finished_timer,
  output logic             busy_timer,
  output logic [CNT_W-1:0] remaining_sec
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic             fin_q;
  logic             busy_q;

  logic [CNT_W-1:0] dur_d;
  logic             dur_ok_d;
  logic             tick_d;

`ifdef WASH_TIMER_FAST_SIM_EN
  assign tick_d = 1'b1;
`else
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;

  assign tick_d = (presc_q == PMAX);
`endif

  always_comb begin
    dur_d    = '0;
    dur_ok_d = 1'b1;
    case (state_timer)
      3'b001:  dur_d = CNT_W'(FILL_SEC);
      3'b010:  dur_d = CNT_W'(WASH_SEC);
      3'b011:  dur_d = CNT_W'(RINSE_SEC);
      3'b100:  dur_d = CNT_W'(SPIN_SEC);
      default: dur_ok_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_timer) begin
    if (rst_timer) begin
      state_q <= IDLE;
      rem_q   <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifndef WASH_TIMER_FAST_SIM_EN
      presc_q <= '0;
`endif
    end else begin
      fin_q <= 1'b0;
      if (start_timer && dur_ok_d) begin
        rem_q   <= dur_d;
        busy_q  <= 1'b1;
        state_q <= pause_timer ? HOLD : RUN;
`ifndef WASH_TIMER_FAST_SIM_EN
        presc_q <= '0;
`endif
      end else if (state_q != IDLE) begin
        if (pause_timer) begin
          state_q <= HOLD;
        end else begin
          // Releasing pause counts on the same edge, so a pause of N cycles costs N.
          state_q <= RUN;
          if (rem_q == '0) begin
            fin_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
`ifndef WASH_TIMER_FAST_SIM_EN
            presc_q <= tick_d ? '0 : presc_q + 1'b1;
`endif
            if (tick_d) begin
              rem_q <= rem_q - 1'b1;
              if (rem_q == CNT_W'(1)) begin
                fin_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
        end
      end
    end
  end

  assign finished_timer = fin_q;
  assign busy_timer     = busy_q;
  assign remaining_sec  = rem_q;

endmodule
